envelope_vca: RTL and testbench

Sample-rate amplitude stage placed directly downstream of biquad_filter. It consumes the filter's signed Q2.14 `dout` stream and scales it by an internally generated ADSR envelope that is driven by a `gate` input. Its output feeds the synth output path.

---
 rtl/envelope_vca.sv | 127 ++++++++++++
 tb/tb_envelope_vca.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// ADSR envelope generator driven by a note gate, scaling the Q2.14 filter stream.
// dout is din times env (env read as unsigned ~1.0), registered for one cycle.
module envelope_vca #(
    parameter int                   DATA_WIDTH    = 16,
    parameter int                   ENV_WIDTH     = 16,
    parameter int                   RATE_DIV      = 1,
    parameter logic [ENV_WIDTH-1:0] ATTACK_STEP   = 16'h1000,
    parameter logic [ENV_WIDTH-1:0] DECAY_STEP    = 16'h0800,
    parameter logic [ENV_WIDTH-1:0] SUSTAIN_LEVEL = 16'h8000,
    parameter logic [ENV_WIDTH-1:0] RELEASE_STEP  = 16'h0400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gate,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ENV_WIDTH-1:0]  env,
    output logic [2:0]            state,
    output logic                  active
);
    localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RATE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                state_q, state_nxt;
    logic [ENV_WIDTH-1:0]  env_q, env_nxt;
    logic [CW-1:0]         cnt;
    logic                  tick, gate_d, rise;
    logic [ENV_WIDTH:0]    att_sum, dec_diff;
    logic signed [DATA_WIDTH+ENV_WIDTH:0] prod;

    assign tick = (cnt == CNT_MAX);
    assign rise = gate & ~gate_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            gate_d <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            gate_d <= gate;
        end
    end

    // Extra top bit catches attack overflow and decay underflow.
    assign att_sum  = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    assign dec_diff = {1'b0, env_q} - {1'b0, DECAY_STEP};

    always_comb begin
        state_nxt = state_q;
        env_nxt   = env_q;
        case (state_q)
            S_IDLE: begin
                env_nxt = '0;
                if (rise) state_nxt = S_ATTACK;
            end
            S_ATTACK: begin
                if (!gate) state_nxt = S_RELEASE;
                else if (tick) begin
                    if (att_sum[ENV_WIDTH]) begin
                        env_nxt   = '1;
                        state_nxt = S_DECAY;
                    end else begin
                        env_nxt = att_sum[ENV_WIDTH-1:0];
                    end
                end
            end
            S_DECAY: begin
                if (!gate) state_nxt = S_RELEASE;
                else if (tick) begin
                    if (dec_diff[ENV_WIDTH] || dec_diff[ENV_WIDTH-1:0] <= SUSTAIN_LEVEL) begin
                        env_nxt   = SUSTAIN_LEVEL;
                        state_nxt = S_SUSTAIN;
                    end else begin
                        env_nxt = dec_diff[ENV_WIDTH-1:0];
                    end
                end
            end
            S_SUSTAIN: begin
                if (!gate) state_nxt = S_RELEASE;
                else env_nxt = SUSTAIN_LEVEL;
            end
            S_RELEASE: begin
                // Retrigger keeps the current level so the attack ramps from there.
                if (rise) state_nxt = S_ATTACK;
                else if (tick) begin
                    if (env_q <= RELEASE_STEP) begin
                        env_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        env_nxt = env_q - RELEASE_STEP;
                    end
                end
            end
            default: begin
                env_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // env is non-negative, so the multiply never grows |din|.
    assign prod = $signed(din) * $signed({1'b0, env_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            env_q   <= '0;
            dout    <= '0;
        end else begin
            state_q <= state_nxt;
            env_q   <= env_nxt;
            dout    <= DATA_WIDTH'(prod >>> ENV_WIDTH);
        end
    end

    assign env    = env_q;
    assign state  = state_q;
    assign active = (state_q != S_IDLE);
endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: one instance at RATE_DIV=1, one at RATE_DIV=4.
module tb_envelope_vca;
    logic        clk = 1'b0;
    logic        reset = 1'b0, r4 = 1'b0;
    logic        g1 = 1'b0, g4 = 1'b0;
    logic [15:0] din = 16'hC000;
    logic [15:0] dout1, env1, dout4, env4;
    logic [2:0]  st1, st4;
    logic        act1, act4;
    int          errors = 0, checks = 0;

    envelope_vca dut1 (.clk(clk), .reset(reset), .gate(g1), .din(din),
                       .dout(dout1), .env(env1), .state(st1), .active(act1));

    envelope_vca #(.RATE_DIV(4)) dut4 (.clk(clk), .reset(r4), .gate(g4), .din(din),
                       .dout(dout4), .env(env4), .state(st4), .active(act4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        chk("rst_env", 32'(env1), 32'h0);
        chk("rst_state", 32'(st1), 32'h0);
        chk("rst_dout", 32'(dout1), 32'h0);
        chk("rst_active", 32'(act1), 32'h0);

        // Reset mid-attack
        reset = 1'b1;
        g1 = 1'b1;
        step();
        chk("pre_att_state", 32'(st1), 32'h1);
        step(3);
        chk("pre_att_env", 32'(env1), 32'h3000);
        #3;
        reset = 1'b0;
        g1 = 1'b0;
        #1;
        chk("async_env", 32'(env1), 32'h0);
        chk("async_state", 32'(st1), 32'h0);
        chk("async_dout", 32'(dout1), 32'h0);
        chk("async_active", 32'(act1), 32'h0);
        step();
        reset = 1'b1;
        step(3);
        chk("post_rst_state", 32'(st1), 32'h0);
        chk("post_rst_env", 32'(env1), 32'h0);

        // Attack
        g1 = 1'b1;
        step();
        chk("att_enter", 32'(st1), 32'h1);
        chk("att_env0", 32'(env1), 32'h0);
        chk("att_active", 32'(act1), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("att_env", 32'(env1), 32'(i * 32'h1000));
        end
        step();
        chk("att_clamp_env", 32'(env1), 32'hFFFF);
        chk("att_clamp_state", 32'(st1), 32'h2);
        chk("att_dout_f000", 32'(dout1), 32'hC400);

        // Decay
        step();
        chk("dec_dout_full", 32'(dout1), 32'hC000);
        chk("dec_env1", 32'(env1), 32'hF7FF);
        for (int k = 2; k <= 15; k++) begin
            step();
            chk("dec_env", 32'(env1), 32'h0000FFFF - 32'(k * 32'h800));
        end
        step();
        chk("dec_clamp_env", 32'(env1), 32'h8000);
        chk("dec_clamp_state", 32'(st1), 32'h3);
        step();
        chk("sus_dout", 32'(dout1), 32'hE000);
        chk("sus_state", 32'(st1), 32'h3);
        step();
        chk("sus_dout_stable", 32'(dout1), 32'hE000);
        chk("sus_env_stable", 32'(env1), 32'h8000);

        // Release to idle
        g1 = 1'b0;
        step();
        chk("rel_enter", 32'(st1), 32'h4);
        chk("rel_env0", 32'(env1), 32'h8000);
        for (int j = 1; j <= 31; j++) begin
            step();
            chk("rel_env", 32'(env1), 32'h8000 - 32'(j * 32'h400));
        end
        step();
        chk("rel_end_env", 32'(env1), 32'h0);
        chk("rel_end_state", 32'(st1), 32'h0);
        chk("rel_end_active", 32'(act1), 32'h0);
        chk("rel_dout_400", 32'(dout1), 32'hFF00);
        step();
        chk("idle_dout", 32'(dout1), 32'h0);

        // Retrigger from release at 0x4000
        g1 = 1'b1;
        step();
        chk("rt_att", 32'(st1), 32'h1);
        step(8);
        chk("rt_att_env", 32'(env1), 32'h8000);
        g1 = 1'b0;
        step();
        chk("rt_rel_state", 32'(st1), 32'h4);
        chk("rt_rel_env", 32'(env1), 32'h8000);
        step(16);
        chk("rt_rel_4000", 32'(env1), 32'h4000);
        g1 = 1'b1;
        step();
        chk("rt_state", 32'(st1), 32'h1);
        chk("rt_env_hold", 32'(env1), 32'h4000);
        step();
        chk("rt_env_5000", 32'(env1), 32'h5000);
        step();
        chk("rt_env_6000", 32'(env1), 32'h6000);

        // RATE_DIV=4: ticks land on every 4th edge after reset release
        chk("d4_rst_env", 32'(env4), 32'h0);
        r4 = 1'b1;
        g4 = 1'b1;
        step();
        chk("d4_att", 32'(st4), 32'h1);
        step(2);
        chk("d4_no_tick", 32'(env4), 32'h0);
        step();
        chk("d4_tick1", 32'(env4), 32'h1000);
        step(8);
        chk("d4_tick3", 32'(env4), 32'h3000);
        step(3);
        chk("d4_pre_fall", 32'(env4), 32'h3000);
        g4 = 1'b0;
        step();
        chk("d4_fall_state", 32'(st4), 32'h4);
        chk("d4_fall_env", 32'(env4), 32'h3000);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("d4_hold_a", 32'(env4), 32'h3000);
        end
        step();
        chk("d4_rel1", 32'(env4), 32'h2C00);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("d4_hold_b", 32'(env4), 32'h2C00);
        end
        step();
        chk("d4_rel2", 32'(env4), 32'h2800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
